// File: rtl/imem_loader_fetch_if.sv
// Fetch and program-load bus between the core/loader (master) and imem_loader_fetch (slave).
interface imem_loader_fetch_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16
);
   logic              stall;
   logic              flush;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] instruction;
   logic              inst_valid;
   logic              addr_fault;
   logic              prog_start;
   logic              prog_valid;
   logic              prog_ready;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;
   logic              prog_done;
   logic              busy;
   logic [CNT_W-1:0]  fetch_count;
   logic              parity_err;

   modport master (
      output stall, flush, pc, prog_start, prog_valid, prog_addr, prog_data, prog_done,
      input  instruction, inst_valid, addr_fault, prog_ready, busy, fetch_count, parity_err
   );

   modport slave (
      input  stall, flush, pc, prog_start, prog_valid, prog_addr, prog_data, prog_done,
      output instruction, inst_valid, addr_fault, prog_ready, busy, fetch_count, parity_err
   );
endinterface

// File: rtl/imem_loader_fetch.sv
// Loadable instruction memory: LOAD state accepts program writes, RUN state serves registered fetches.
// Optional per-word even parity checking is enabled by defining IMEM_PARITY_EN.
module imem_loader_fetch #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter int                DEPTH    = 65536,
   parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}},
   parameter int                CNT_W    = 16
) (
   input logic                clk,
   input logic                rst_n,
   imem_loader_fetch_if.slave bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic logic even_par(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

   state_t            r_state;
   state_t            w_state_nxt;
   logic [MEM_W-1:0]  r_mem [DEPTH];
   logic [DATA_W-1:0] r_instruction;
   logic              r_inst_valid;
   logic              r_addr_fault;
   logic [CNT_W-1:0]  r_fetch_count;
   logic              r_parity_err;

   logic [DATA_W-1:0] w_inst_nxt;
   logic              w_valid_nxt;
   logic              w_fault_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_par_nxt;
   logic              w_pc_in_range;
   logic              w_wr_in_range;
   logic              w_wr_en;
   logic [IDX_W-1:0]  w_rd_idx;
   logic [IDX_W-1:0]  w_wr_idx;
   logic [MEM_W-1:0]  w_rd_word;
   logic [MEM_W-1:0]  w_wr_word;
   logic              w_rd_par_err;

   assign w_pc_in_range = ({1'b0, bus.pc} < DEPTH_L);
   assign w_wr_in_range = ({1'b0, bus.prog_addr} < DEPTH_L);
   assign w_rd_idx      = bus.pc[IDX_W-1:0];
   assign w_wr_idx      = bus.prog_addr[IDX_W-1:0];
   // Out-of-range program writes still handshake but never reach the array.
   assign w_wr_en       = rst_n && (r_state == ST_LOAD) && bus.prog_valid && w_wr_in_range;
   assign w_rd_word     = r_mem[w_rd_idx];

`ifdef IMEM_PARITY_EN
   assign w_wr_word    = {even_par(bus.prog_data), bus.prog_data};
   assign w_rd_par_err = w_rd_word[DATA_W] ^ even_par(w_rd_word[DATA_W-1:0]);
`else
   assign w_wr_word    = bus.prog_data;
   assign w_rd_par_err = 1'b0;
`endif

   // Program storage; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_idx] <= w_wr_word;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: prog_done ends loading, prog_start re-enters it.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_LOAD: begin
            if (bus.prog_done) w_state_nxt = ST_RUN;
            else               w_state_nxt = ST_LOAD;
         end
         ST_RUN: begin
            if (bus.prog_start) w_state_nxt = ST_LOAD;
            else                w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   // Fetch output next values in priority order: reload, flush, stall, in-range, out-of-range.
   always_comb begin
      w_inst_nxt  = r_instruction;
      w_valid_nxt = r_inst_valid;
      w_fault_nxt = r_addr_fault;
      w_cnt_nxt   = r_fetch_count;
      w_par_nxt   = r_parity_err;
      case (r_state)
         ST_LOAD: begin
            w_inst_nxt  = NOP_WORD;
            w_valid_nxt = 1'b0;
            w_fault_nxt = 1'b0;
            w_par_nxt   = 1'b0;
            if (bus.prog_done) w_cnt_nxt = {CNT_W{1'b0}};
            else               w_cnt_nxt = r_fetch_count;
         end
         ST_RUN: begin
            if (bus.prog_start || bus.flush) begin
               w_inst_nxt  = NOP_WORD;
               w_valid_nxt = 1'b0;
               w_fault_nxt = 1'b0;
               w_par_nxt   = 1'b0;
            end else if (bus.stall) begin
               w_inst_nxt  = r_instruction;
               w_valid_nxt = r_inst_valid;
               w_fault_nxt = r_addr_fault;
               w_par_nxt   = r_parity_err;
            end else if (w_pc_in_range) begin
               w_inst_nxt  = w_rd_word[DATA_W-1:0];
               w_valid_nxt = 1'b1;
               w_fault_nxt = 1'b0;
               w_par_nxt   = w_rd_par_err;
               w_cnt_nxt   = r_fetch_count + CNT_W'(1);
            end else begin
               w_inst_nxt  = NOP_WORD;
               w_valid_nxt = 1'b1;
               w_fault_nxt = 1'b1;
               w_par_nxt   = 1'b0;
               w_cnt_nxt   = r_fetch_count + CNT_W'(1);
            end
         end
         default: begin
            w_inst_nxt  = NOP_WORD;
            w_valid_nxt = 1'b0;
            w_fault_nxt = 1'b0;
            w_par_nxt   = 1'b0;
            w_cnt_nxt   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Registered fetch outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instruction <= NOP_WORD;
         r_inst_valid  <= 1'b0;
         r_addr_fault  <= 1'b0;
         r_fetch_count <= {CNT_W{1'b0}};
         r_parity_err  <= 1'b0;
      end else begin
         r_instruction <= w_inst_nxt;
         r_inst_valid  <= w_valid_nxt;
         r_addr_fault  <= w_fault_nxt;
         r_fetch_count <= w_cnt_nxt;
         r_parity_err  <= w_par_nxt;
      end
   end

   assign bus.instruction = r_instruction;
   assign bus.inst_valid  = r_inst_valid;
   assign bus.addr_fault  = r_addr_fault;
   assign bus.fetch_count = r_fetch_count;
   assign bus.parity_err  = r_parity_err;
   // Ready is forced low while reset is held even though the state already reads LOAD.
   assign bus.prog_ready  = (r_state == ST_LOAD) && rst_n;
   assign bus.busy        = (r_state == ST_LOAD) && rst_n;

endmodule

// File: tb/tb_imem_loader_fetch.sv
// Randomised scoreboard bench for imem_loader_fetch (DEPTH=16) against a behavioural model.
module tb_imem_loader_fetch;

   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int CW    = 16;
   localparam int DEPTH = 16;

   typedef struct {
      logic [DW-1:0] inst;
      logic          valid;
      logic          fault;
      logic          ready;
      logic          par;
      logic [CW-1:0] cnt;
      int            due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   bit            m_run;
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_corrupt [DEPTH];
   exp_t          m_out;

   imem_loader_fetch_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

   imem_loader_fetch #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NOP_WORD(16'h0000), .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compare every output sample whose edge has already happened.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         exp_t e;
         e = q.pop_front();
         chk("instruction", 32'(bus.instruction), 32'(e.inst));
         chk("inst_valid",  32'(bus.inst_valid),  32'(e.valid));
         chk("addr_fault",  32'(bus.addr_fault),  32'(e.fault));
         chk("fetch_count", 32'(bus.fetch_count), 32'(e.cnt));
         chk("prog_ready",  32'(bus.prog_ready),  32'(e.ready));
         chk("busy",        32'(bus.busy),        32'(e.ready));
         chk("parity_err",  32'(bus.parity_err),  32'(e.par));
      end
   end

   task automatic model_reset();
      m_run       = 1'b0;
      m_out.inst  = 16'h0000;
      m_out.valid = 1'b0;
      m_out.fault = 1'b0;
      m_out.par   = 1'b0;
      m_out.cnt   = 16'h0000;
      m_out.ready = 1'b1;
   endtask

   task automatic step(input logic st, input logic fl, input logic [AW-1:0] p,
                       input logic ps, input logic pv, input logic [AW-1:0] pa,
                       input logic [DW-1:0] pd, input logic pdn);
      bus.stall = st; bus.flush = fl; bus.pc = p; bus.prog_start = ps;
      bus.prog_valid = pv; bus.prog_addr = pa; bus.prog_data = pd; bus.prog_done = pdn;
      if (!m_run) begin
         if (pv && pa < AW'(DEPTH)) begin
            m_mem[pa[3:0]]     = pd;
            m_corrupt[pa[3:0]] = 1'b0;
         end
         m_out.inst = 16'h0000; m_out.valid = 1'b0; m_out.fault = 1'b0; m_out.par = 1'b0;
         if (pdn) begin
            m_run     = 1'b1;
            m_out.cnt = 16'h0000;
         end
      end else if (ps || fl) begin
         if (ps) m_run = 1'b0;
         m_out.inst = 16'h0000; m_out.valid = 1'b0; m_out.fault = 1'b0; m_out.par = 1'b0;
      end else if (!st) begin
         if (p < AW'(DEPTH)) begin
            m_out.inst  = m_mem[p[3:0]];
            m_out.fault = 1'b0;
            m_out.par   = m_corrupt[p[3:0]];
         end else begin
            m_out.inst  = 16'h0000;
            m_out.fault = 1'b1;
            m_out.par   = 1'b0;
         end
         m_out.valid = 1'b1;
         m_out.cnt   = m_out.cnt + 16'd1;
      end
      m_out.ready = !m_run;
      m_out.due   = cyc + 1;
      q.push_back(m_out);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [AW-1:0] p);
      step(1'b0, 1'b0, p, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
   endtask

   task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic done);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, a, d, done);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.stall = 1'b0; bus.flush = 1'b0; bus.pc = 16'h0000; bus.prog_start = 1'b0;
      bus.prog_valid = 1'b0; bus.prog_addr = 16'h0000; bus.prog_data = 16'h0000;
      bus.prog_done = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_corrupt[i] = 1'b0;
      model_reset();

      #12;
      chk("rst_ready", 32'(bus.prog_ready), 32'd0);
      chk("rst_busy",  32'(bus.busy),       32'd0);
      chk("rst_inst",  32'(bus.instruction), 32'h0000);
      chk("rst_valid", 32'(bus.inst_valid), 32'd0);
      chk("rst_count", 32'(bus.fetch_count), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_ready", 32'(bus.prog_ready), 32'd1);
      @(posedge clk);
      #1;

      // Basic load and three fetches.
      write(16'h0000, 16'h6242, 1'b0);
      write(16'h0001, 16'h0E49, 1'b0);
      write(16'h000C, 16'h5281, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      fetch(16'h0000);
      fetch(16'h0001);
      fetch(16'h000C);
      chk("plan_inst", 32'(bus.instruction), 32'h5281);
      chk("plan_cnt",  32'(bus.fetch_count), 32'd3);

      // Stall hold, then flush together with stall.
      fetch(16'h0001);
      step(1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      step(1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      step(1'b1, 1'b0, 16'h0004, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      chk("stall_inst", 32'(bus.instruction), 32'h0E49);
      step(1'b1, 1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

      // Out of range then back in range.
      fetch(16'h0020);
      chk("oor_fault", 32'(bus.addr_fault), 32'd1);
      fetch(16'h0000);

      // Reload: discarded high write, write on the prog_done edge.
      step(1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      chk("reload_ready", 32'(bus.prog_ready), 32'd1);
      write(16'h0030, 16'hFFFF, 1'b0);
      write(16'h0005, 16'hABCD, 1'b1);
      fetch(16'h0005);
      fetch(16'h0000);

      // Fill the whole array, then random traffic.
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      for (int i = 0; i < DEPTH; i++) write(AW'(i), DW'($urandom), 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) == 0, ($urandom % 6) == 0, AW'($urandom_range(0, 20)),
              ($urandom % 40) == 0, ($urandom % 2) == 0, AW'($urandom_range(0, 20)),
              DW'($urandom), ($urandom % 10) == 0);
      end

      // Asynchronous reset mid-fetch; memory survives.
      if (!m_run) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      fetch(16'h0003);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_inst",  32'(bus.instruction), 32'h0000);
      chk("arst_valid", 32'(bus.inst_valid),  32'd0);
      chk("arst_ready", 32'(bus.prog_ready),  32'd0);
      chk("arst_count", 32'(bus.fetch_count), 32'd0);
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      for (int i = 0; i < DEPTH; i++) fetch(AW'(i));

`ifdef IMEM_PARITY_EN
      dut.r_mem[3][0] = ~dut.r_mem[3][0];
      m_mem[3][0]     = ~m_mem[3][0];
      m_corrupt[3]    = 1'b1;
      fetch(16'h0003);
      chk("par_err_set", 32'(bus.parity_err), 32'd1);
      fetch(16'h0000);
      chk("par_err_clr", 32'(bus.parity_err), 32'd0);
`endif

      @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
